// File: rtl/vga_text_pkg.sv
// Shared constants for the 40x30 text-cell RAM: geometry, control codes and writer states.
// The display-side address generator uses the same geometry and cell_addr().
package vga_text_pkg;

  localparam int COLS   = 40;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 11;
  localparam int CELLS  = COLS * ROWS;

  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [6:0] CH_BS = 7'h08;
  localparam logic [6:0] CH_LF = 7'h0A;
  localparam logic [6:0] CH_FF = 7'h0C;
  localparam logic [6:0] CH_CR = 7'h0D;

  localparam logic [5:0]        LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW1_ADDR = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SC_RD,
    ST_SC_WAIT,
    ST_SC_WR,
    ST_CLR_ROW,
    ST_CLR_ALL
  } text_state_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/vga_text_writer.sv
// Writer side of the text-cell RAM: byte stream in, glyph writes, wrap, scroll and clear on port B.
// state      | meaning
// ST_IDLE    | accepting bytes (after reset, one cycle here before the power-on clear)
// ST_SC_RD   | scroll: present source address
// ST_SC_WAIT | scroll: RAM read latency
// ST_SC_WR   | scroll: write read data to destination
// ST_CLR_ROW | blank the bottom row after a scroll
// ST_CLR_ALL | blank the whole screen
module vga_text_writer
  import vga_text_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [5:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  text_state_t       state, state_nx;
  logic              init_pend, init_nx;
  logic [5:0]        col, col_nx;
  logic [4:0]        row, row_nx;
  logic [ADDR_W-1:0] src, src_nx;
  logic [ADDR_W-1:0] dst, dst_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic              we_nx;
  logic [7:0]        wdata_nx;
  logic              newline;
  logic [6:0]        code;
  logic              printable;

  assign code       = char_data[6:0];
  assign printable  = (code >= 7'h20) && (code <= 7'h7E);
  // init_pend holds off acceptance for the single cycle before the power-on clear
  assign char_ready = (state == ST_IDLE) && !reset && !init_pend;
  assign busy       = (state != ST_IDLE);
  assign cursor_col = col;
  assign cursor_row = row;

  always_comb begin
    state_nx = state;
    init_nx  = init_pend;
    col_nx   = col;
    row_nx   = row;
    src_nx   = src;
    dst_nx   = dst;
    addr_nx  = mem_addr;
    we_nx    = 1'b0;
    wdata_nx = mem_wdata;
    newline  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (init_pend) begin
          init_nx  = 1'b0;
          dst_nx   = '0;
          state_nx = ST_CLR_ALL;
        end else if (char_valid) begin
          if (printable) begin
            we_nx    = 1'b1;
            addr_nx  = cell_addr(row, col);
            wdata_nx = char_data;
            if (col < LAST_COL) begin
              col_nx = col + 6'd1;
            end else begin
              col_nx  = '0;
              newline = 1'b1;
            end
          end else if (code == CH_LF) begin
            col_nx  = '0;
            newline = 1'b1;
          end else if (code == CH_CR) begin
            col_nx = '0;
          end else if (code == CH_BS) begin
            if (col != '0) col_nx = col - 6'd1;
          end else if (code == CH_FF) begin
            col_nx   = '0;
            row_nx   = '0;
            dst_nx   = '0;
            state_nx = ST_CLR_ALL;
          end
          if (newline) begin
            if (row < LAST_ROW) begin
              row_nx = row + 5'd1;
            end else begin
              src_nx   = ROW1_ADDR;
              dst_nx   = '0;
              state_nx = ST_SC_RD;
            end
          end
        end
      end
      ST_SC_RD: begin
        addr_nx  = src;
        state_nx = ST_SC_WAIT;
      end
      ST_SC_WAIT: state_nx = ST_SC_WR;
      ST_SC_WR: begin
        we_nx    = 1'b1;
        addr_nx  = dst;
        wdata_nx = mem_rdata;
        src_nx   = src + ADDR_W'(1);
        dst_nx   = dst + ADDR_W'(1);
        // dst lands on the first bottom-row cell, ready for ST_CLR_ROW
        state_nx = (src == LAST_ADDR) ? ST_CLR_ROW : ST_SC_RD;
      end
      ST_CLR_ROW, ST_CLR_ALL: begin
        we_nx    = 1'b1;
        addr_nx  = dst;
        wdata_nx = BLANK;
        dst_nx   = dst + ADDR_W'(1);
        if (dst == LAST_ADDR) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      init_pend <= CLEAR_ON_RESET;
      col       <= '0;
      row       <= '0;
      src       <= '0;
      dst       <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nx;
      init_pend <= init_nx;
      col       <= col_nx;
      row       <= row_nx;
      src       <= src_nx;
      dst       <= dst_nx;
      mem_addr  <= addr_nx;
      mem_we    <= we_nx;
      mem_wdata <= wdata_nx;
    end
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// Self-checking bench for vga_text_writer: text RAM model on port B plus a screen-level reference.
module tb_vga_text_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  vga_text_writer #(.CLEAR_ON_RESET(1'b1)) dut (
    .clock(clock), .reset(reset), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [7:0] ram [0:2047];
  int wr_cnt = 0, nb_cnt = 0, bad_addr = 0;

  always @(posedge clock) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt   <= wr_cnt + 1;
      if (mem_wdata != 8'h20) nb_cnt <= nb_cnt + 1;
      if (mem_addr > 11'd1199) bad_addr <= bad_addr + 1;
    end
    mem_rdata <= ram[mem_addr];
  end

  // screen-level reference model
  logic [7:0] model [0:1199];
  int mrow = 0, mcol = 0;
  int n_cmp = 0, n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_cursor(input string nm, input int r, input int c);
    check({nm, "_row"}, 32'(cursor_row), r);
    check({nm, "_col"}, 32'(cursor_col), c);
  endtask

  task automatic check_screen(input string nm);
    int diffs = 0, first = -1;
    for (int i = 0; i < 1200; i++)
      if (ram[i] !== model[i]) begin
        diffs++;
        if (first < 0) first = i;
      end
    n_cmp++;
    if (diffs != 0) begin
      n_err++;
      $display("FAIL %s: %0d cells differ, first at %0d got %0h expected %0h",
               nm, diffs, first, ram[first], model[first]);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 1200; i++) model[i] = 8'h20;
    mrow = 0;
    mcol = 0;
  endfunction

  function automatic void model_newline();
    if (mrow < 29) mrow++;
    else begin
      for (int i = 0; i < 1160; i++) model[i] = model[i + 40];
      for (int i = 1160; i < 1200; i++) model[i] = 8'h20;
    end
  endfunction

  function automatic void model_put(input logic [7:0] b);
    logic [6:0] c;
    c = b[6:0];
    if (c >= 7'h20 && c <= 7'h7E) begin
      model[mrow * 40 + mcol] = b;
      mcol++;
      if (mcol == 40) begin
        mcol = 0;
        model_newline();
      end
    end else if (c == 7'h0A) begin
      mcol = 0;
      model_newline();
    end else if (c == 7'h0D) mcol = 0;
    else if (c == 7'h08) begin
      if (mcol > 0) mcol--;
    end else if (c == 7'h0C) model_clear();
  endfunction

  task automatic wait_idle(output int n);
    n = 0;
    while (!char_ready && n < 6000) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!char_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: got 0 expected 1 after %0d cycles", n);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    wait_idle(n);
    char_valid = 1'b1;
    char_data  = b;
    @(posedge clock);
    #1;
    char_valid = 1'b0;
    model_put(b);
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        we;
    logic [10:0] addr;
    logic [7:0]  wdata;
    int          row;
    int          col;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int n, w0, nb0, r;
    logic [7:0] b;

    vecs[0]  = '{8'h41, 1'b1, 11'd0,  8'h41, 0, 1};
    vecs[1]  = '{8'h42, 1'b1, 11'd1,  8'h42, 0, 2};
    vecs[2]  = '{8'hC1, 1'b1, 11'd2,  8'hC1, 0, 3};
    vecs[3]  = '{8'h08, 1'b0, 11'd0,  8'h00, 0, 2};
    vecs[4]  = '{8'h7F, 1'b0, 11'd0,  8'h00, 0, 2};
    vecs[5]  = '{8'h01, 1'b0, 11'd0,  8'h00, 0, 2};
    vecs[6]  = '{8'h0A, 1'b0, 11'd0,  8'h00, 1, 0};
    vecs[7]  = '{8'h08, 1'b0, 11'd0,  8'h00, 1, 0};
    vecs[8]  = '{8'h0D, 1'b0, 11'd0,  8'h00, 1, 0};
    vecs[9]  = '{8'h7E, 1'b1, 11'd40, 8'h7E, 1, 1};
    vecs[10] = '{8'hA0, 1'b1, 11'd41, 8'hA0, 1, 2};
    vecs[11] = '{8'h8A, 1'b0, 11'd0,  8'h00, 2, 0};
    vecs[12] = '{8'h0D, 1'b0, 11'd0,  8'h00, 2, 0};

    for (int i = 0; i < 2048; i++) ram[i] = 8'hFF;

    // reset values and power-on clear
    repeat (3) @(posedge clock);
    #1;
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_ready", char_ready, 0);
    check("rst_busy", busy, 0);
    check_cursor("rst_cursor", 0, 0);
    w0 = wr_cnt;
    reset = 1'b0;
    settle();
    check("post_rst_ready", char_ready, 0);
    wait_idle(n);
    settle();
    model_clear();
    check("poweron_writes", wr_cnt - w0, 1200);
    check_screen("poweron_screen");
    check("poweron_ready", char_ready, 1);
    check_cursor("poweron_cursor", 0, 0);

    // back-to-back table vectors
    for (int i = 0; i < 13; i++) begin
      char_valid = 1'b1;
      char_data  = vecs[i].data;
      @(posedge clock);
      #1;
      model_put(vecs[i].data);
      check($sformatf("vec%0d_we", i), mem_we, vecs[i].we);
      if (vecs[i].we) begin
        check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
        check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].wdata);
      end
      check_cursor($sformatf("vec%0d", i), vecs[i].row, vecs[i].col);
    end
    char_valid = 1'b0;
    settle();
    check_screen("vec_screen");

    // form feed clear duration
    send_byte(8'h0C);
    w0 = wr_cnt;
    wait_idle(n);
    check("ff_busy_cycles", n, 1200);
    settle();
    check("ff_writes", wr_cnt - w0, 1200);
    check_screen("ff_screen");

    // wrap at end of row 0, then CR and BS at column 0
    for (int i = 0; i < 39; i++) send_byte(8'h20);
    send_byte(8'h5A);
    check("wrap_we", mem_we, 1);
    check("wrap_addr", mem_addr, 39);
    check("wrap_wdata", mem_wdata, 8'h5A);
    check_cursor("wrap_cursor", 1, 0);
    settle();
    w0 = wr_cnt;
    send_byte(8'h0D);
    send_byte(8'h08);
    settle();
    check("crbs_writes", wr_cnt - w0, 0);
    check_cursor("crbs_cursor", 1, 0);

    // fill row 29 with the screen preloaded as row r holds r
    for (int i = 0; i < 28; i++) send_byte(8'h0A);
    check_cursor("row29_cursor", 29, 0);
    for (int i = 0; i < 1200; i++) begin
      ram[i]   = 8'(i / 40);
      model[i] = 8'(i / 40);
    end
    for (int i = 0; i < 40; i++) send_byte(8'h58);
    wait_idle(n);
    check("scroll_busy_cycles", n, 3520);
    check_cursor("scroll_cursor", 29, 0);
    send_byte(8'h58);
    check("x41_addr", mem_addr, 1160);
    check_cursor("x41_cursor", 29, 1);
    settle();
    check_screen("fill_screen");
    check("row27_cell", ram[1080], 8'd28);
    check("row28_cell", ram[1120], 8'h58);
    check("row29_blank", ram[1199], 8'h20);

    // LF on the last row scrolls; FF clears
    send_byte(8'h0A);
    wait_idle(n);
    settle();
    check_screen("lf_scroll_screen");
    check_cursor("lf_scroll_cursor", 29, 0);
    send_byte(8'h0C);
    wait_idle(n);
    settle();
    check_screen("ff2_screen");
    check_cursor("ff2_cursor", 0, 0);

    // randomized stream against the screen model
    for (int i = 0; i < 1200; i++) begin
      b = 8'($urandom);
      ram[i]   = b;
      model[i] = b;
    end
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) b = {1'($urandom), 7'($urandom_range(32, 126))};
      else if (r < 82) b = 8'h0A;
      else if (r < 88) b = 8'h0D;
      else if (r < 94) b = 8'h08;
      else if (r < 98) begin
        b = 8'($urandom_range(0, 31));
        if (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'h7F;
      end else b = 8'h0C;
      send_byte(b);
      wait_idle(n);
      check_cursor($sformatf("rand%0d", i), mrow, mcol);
    end
    settle();
    check_screen("rand_screen");

    // reset in the middle of a scroll
    send_byte(8'h0C);
    for (int i = 0; i < 29; i++) send_byte(8'h0A);
    send_byte(8'h0A);
    repeat (499) @(posedge clock);
    #1;
    check("mid_scroll_busy", busy, 1);
    reset = 1'b1;
    settle();
    check("abort_we", mem_we, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", char_ready, 0);
    check_cursor("abort_cursor", 0, 0);
    reset = 1'b0;
    w0  = wr_cnt;
    nb0 = nb_cnt;
    wait_idle(n);
    settle();
    model_clear();
    check("abort_writes", wr_cnt - w0, 1200);
    check("abort_nonblank", nb_cnt - nb0, 0);
    check_screen("abort_screen");
    check("addr_range", bad_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_text_writer.md
Name: vga_text_writer

Overview:
Writer side of the 40x30 text-cell RAM that the VGA controller reads.
- Accepts a byte stream over a valid/ready handshake, interprets ASCII control codes, and writes glyph bytes at a hardware cursor.
- Performs line wrap, scroll-up and screen clear through port B of the true-dual-port text RAM.
- Port A of that RAM belongs to the display path.

Parameters:
COLS, 40, cells per row
ROWS, 30, rows per screen
ADDR_W, 11, text RAM address width
BLANK, 8'h20, glyph byte used for clearing (space, invert=0)
CLEAR_ON_RESET, 1, 1 = clear the whole screen after reset

Ports:
clock  in  1  system clock, all logic posedge
reset  in  1  synchronous, active-high
char_valid  in  1  input byte valid
char_data  in  8  [6:0] character code, [7] invert attribute
char_ready  out  1  byte accepted on an edge where valid & ready
mem_addr  out  ADDR_W  RAM port B address, registered
mem_we  out  1  RAM port B write enable, registered
mem_wdata  out  8  RAM port B write data, registered
mem_rdata  in  8  RAM port B read data; valid the cycle after the edge that sampled mem_addr
cursor_col  out  6  current column, 0..COLS-1
cursor_row  out  5  current row, 0..ROWS-1
busy  out  1  scroll or clear in progress

Behaviour:
Reset:
- Values: cursor (0,0); mem_we=0, mem_addr=0, mem_wdata=0; char_ready=0; busy=0.
- First cycle after reset: enter CLR_ALL if CLEAR_ON_RESET=1, else IDLE.
- Reset asserted mid-scroll or mid-clear aborts immediately; partially written RAM is not restored.

States: IDLE, SC_RD, SC_WAIT, SC_WR, CLR_ROW, CLR_ALL.
- char_ready = (state==IDLE) and not reset.
- busy = (state != IDLE).

Acceptance in IDLE, decoded on char_data[6:0]:
- 0x20..0x7E printable: on the accepting edge, mem_we<=1, mem_addr<=row*COLS+col, mem_wdata<=char_data (bit 7 kept).
  - If col<COLS-1: col+1.
  - Otherwise col<=0 and the newline rule applies.
- 0x0A LF: col<=0, then the newline rule.
- 0x0D CR: col<=0, no write.
- 0x08 BS: col-1 if col>0, else no-op. No erase, no move to the previous row.
- 0x0C FF: cursor<=(0,0), enter CLR_ALL.
- Any other code, including 0x7F: consumed, no write, no cursor change.
- If nothing is written that cycle, mem_we<=0.

Newline rule:
- If row<ROWS-1: row+1.
- Otherwise row stays ROWS-1 and the block enters SC_RD with src=COLS, dst=0.

Throughput: one printable per cycle in IDLE; back-to-back writes allowed.

Scroll, 3 cycles per cell, mem_we=0 except in SC_WR:
- SC_RD: mem_addr<=src.
- SC_WAIT: idle cycle.
- SC_WR: mem_addr<=dst, mem_wdata<=mem_rdata, mem_we<=1; src+1, dst+1.
- After src = COLS*ROWS-1 is copied (1160 cells), go to CLR_ROW.

CLR_ROW: 40 writes of BLANK to addresses 1160..1199, one per cycle, then IDLE.
- Cursor is (ROWS-1, 0) on return to IDLE.

CLR_ALL: 1200 writes of BLANK to addresses 0..1199, one per cycle, then IDLE.

Busy durations:
- Scroll: char_ready low 3*1160+40 = 3520 cycles.
- Clear: 1200 cycles.

Boundary cases:
- Printable written at (29,39): the write happens first, then scroll; cursor ends at (29,0).
- Addresses never exceed COLS*ROWS-1.
- Arithmetic: address = row*COLS + col computed at ADDR_W bits, no truncation for legal cursor values.

Decomposition:
- Shared package vga_text_pkg: COLS, ROWS, ADDR_W, BLANK, control-code constants (LF, CR, BS, FF), state encoding.
- Same package used by the display-side address generator.
- No sub-module needed; a single FSM with cursor counters suffices.

Test Plan:
- Reset with CLEAR_ON_RESET=1: 1200 writes of 0x20 to 0..1199, then char_ready=1, cursor (0,0).
- Send "AB" then 0xC1: writes 0x41@0, 0x42@1, 0xC1@2 on consecutive cycles; cursor (0,3).
- From (0,39) send 'Z': write 0x5A@39, cursor (1,0). Then CR, BS: cursor (1,0), no writes.
- Fill row 29 via 41 'X' from (29,0), with model RAM preloaded so row r holds r:
  - Row 28 becomes the old row 29.
  - Row 29 ends as 'X'@1160, blanks at 1161..1199.
  - Cursor (29,1); char_ready low exactly 3520 cycles.
- LF at row 29: full scroll; 0x0C: 1200 blank writes, cursor (0,0).
- Assert reset at cycle 500 of a scroll: mem_we=0 next cycle, clear restarts, no further copy writes.
